// File: rtl/vga_rx_decoder.sv
// rtl/vga_rx_decoder.sv - recovers coordinates, data-enable and lock state from an incoming VGA sync/pixel stream
// Define VGA_RX_CRC_EN to add a per-frame CRC-16-CCITT over all displayed pixels.
`ifndef COLOR_RGB_DEPTH
`define COLOR_RGB_DEPTH 24
`endif
`ifndef H_DISP_LEN
`define H_DISP_LEN 11
`endif
`ifndef V_DISP_LEN
`define V_DISP_LEN 10
`endif

module vga_rx_decoder #(
  parameter int H_SYNC   = 128,
  parameter int H_BACK   = 88,
  parameter int H_DISP   = 800,
  parameter int H_TOTAL  = 1056,
  parameter int V_SYNC   = 4,
  parameter int V_BACK   = 23,
  parameter int V_DISP   = 600,
  parameter int V_TOTAL  = 628,
  parameter int SYNC_POL = 1
) (
  input  logic                        clk_vga,
  input  logic                        rst,
  input  logic                        h_sync_i,
  input  logic                        v_sync_i,
  input  logic [`COLOR_RGB_DEPTH-1:0] rgb_i,
  output logic [`H_DISP_LEN-1:0]      x_addr_o,
  output logic [`V_DISP_LEN-1:0]      y_addr_o,
  output logic                        de_o,
  output logic [`COLOR_RGB_DEPTH-1:0] rgb_o,
  output logic                        locked_o,
  output logic                        frame_start_o,
  output logic                        line_err_o,
  output logic                        frame_err_o,
  output logic [15:0]                 frame_crc_o,
  output logic                        crc_valid_o
);

  localparam int RGB_W = `COLOR_RGB_DEPTH;
  localparam int XW    = `H_DISP_LEN;
  localparam int YW    = `V_DISP_LEN;

  localparam logic        POL    = 1'(SYNC_POL);
  localparam logic [11:0] H_ACT0 = 12'(H_SYNC + H_BACK);
  localparam logic [11:0] H_ACT1 = 12'(H_SYNC + H_BACK + H_DISP);
  localparam logic [11:0] H_TOT  = 12'(H_TOTAL);
  localparam logic [10:0] V_ACT0 = 11'(V_SYNC + V_BACK);
  localparam logic [10:0] V_ACT1 = 11'(V_SYNC + V_BACK + V_DISP);
  localparam logic [10:0] V_TOT  = 11'(V_TOTAL);

  typedef enum logic [1:0] {UNLOCK, ACQ, LOCKED} lock_state_t;

  logic             s1_h, s1_v, s1_h_q, s1_v_q;
  logic [RGB_W-1:0] s1_rgb;
  logic             h_edge, v_edge;
  logic [10:0]      hcnt, hcnt_nxt;
  logic [9:0]       vcnt, vcnt_nxt;
  logic             h_seen, v_seen, err_seen;
  logic             h_err, v_err;
  lock_state_t      state, state_nxt;
  logic             lock_d, de_d, fs_d;
  logic [XW-1:0]    x_d;
  logic [YW-1:0]    y_d;
  logic [RGB_W-1:0] rgb_d;

  always_ff @(posedge clk_vga) begin
    if (rst) begin
      s1_h   <= 1'b0;
      s1_v   <= 1'b0;
      s1_h_q <= 1'b0;
      s1_v_q <= 1'b0;
      s1_rgb <= '0;
    end else begin
      s1_h   <= h_sync_i;
      s1_v   <= v_sync_i;
      s1_h_q <= s1_h;
      s1_v_q <= s1_v;
      s1_rgb <= rgb_i;
    end
  end

  // hcnt_nxt/vcnt_nxt are the coordinates of the pixel currently held in stage 1.
  always_comb begin
    h_edge   = (s1_h == POL) && (s1_h_q != POL);
    v_edge   = (s1_v == POL) && (s1_v_q != POL);
    hcnt_nxt = h_edge ? 11'd0 : ((hcnt == 11'h7FF) ? hcnt : hcnt + 11'd1);
    if (v_edge)
      vcnt_nxt = 10'd0;
    else if (h_edge && vcnt != 10'h3FF)
      vcnt_nxt = vcnt + 10'd1;
    else
      vcnt_nxt = vcnt;
    h_err = h_edge && h_seen && (({1'b0, hcnt} + 12'd1) != H_TOT);
    v_err = v_edge && v_seen && (({1'b0, vcnt} + 11'd1) != V_TOT);
  end

  always_ff @(posedge clk_vga) begin
    if (rst) begin
      hcnt     <= '0;
      vcnt     <= '0;
      h_seen   <= 1'b0;
      v_seen   <= 1'b0;
      err_seen <= 1'b0;
    end else begin
      hcnt   <= hcnt_nxt;
      vcnt   <= vcnt_nxt;
      h_seen <= h_seen | h_edge;
      v_seen <= v_seen | v_edge;
      if (v_edge)
        err_seen <= 1'b0;
      else if (h_err)
        err_seen <= 1'b1;
    end
  end

  always_ff @(posedge clk_vga) begin
    if (rst)
      state <= UNLOCK;
    else
      state <= state_nxt;
  end

  // A clean frame is one v period with no bad line, including the line closed by the v edge itself.
  always_comb begin
    state_nxt = state;
    case (state)
      UNLOCK: if (v_edge) state_nxt = ACQ;
      ACQ:    if (v_edge && !v_err && !h_err && !err_seen) state_nxt = LOCKED;
      LOCKED: if (h_err || v_err) state_nxt = UNLOCK;
      default: state_nxt = UNLOCK;
    endcase
  end

  always_comb begin
    lock_d = (state_nxt == LOCKED);
    de_d   = lock_d
             && ({1'b0, hcnt_nxt} >= H_ACT0) && ({1'b0, hcnt_nxt} < H_ACT1)
             && ({1'b0, vcnt_nxt} >= V_ACT0) && ({1'b0, vcnt_nxt} < V_ACT1);
    x_d    = de_d ? XW'(hcnt_nxt - H_ACT0[10:0]) : '0;
    y_d    = de_d ? YW'(vcnt_nxt - V_ACT0[9:0]) : '0;
    rgb_d  = de_d ? s1_rgb : '0;
    fs_d   = de_d && (hcnt_nxt == H_ACT0[10:0]) && (vcnt_nxt == V_ACT0[9:0]);
  end

  always_ff @(posedge clk_vga) begin
    if (rst) begin
      locked_o      <= 1'b0;
      de_o          <= 1'b0;
      x_addr_o      <= '0;
      y_addr_o      <= '0;
      rgb_o         <= '0;
      frame_start_o <= 1'b0;
      line_err_o    <= 1'b0;
      frame_err_o   <= 1'b0;
    end else begin
      locked_o      <= lock_d;
      de_o          <= de_d;
      x_addr_o      <= x_d;
      y_addr_o      <= y_d;
      rgb_o         <= rgb_d;
      frame_start_o <= fs_d;
      line_err_o    <= h_err;
      frame_err_o   <= v_err;
    end
  end

`ifdef VGA_RX_CRC_EN
  logic [15:0] crc_acc, crc_cur;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [RGB_W-1:0] d);
    logic [15:0] r;
    r = c;
    for (int i = RGB_W - 1; i >= 0; i--)
      r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? 16'h1021 : 16'h0000);
    return r;
  endfunction

  // Accumulate from the registered outputs so the CRC covers exactly what downstream sees.
  always_comb crc_cur = de_o ? crc_step(crc_acc, rgb_o) : crc_acc;

  always_ff @(posedge clk_vga) begin
    if (rst) begin
      crc_acc     <= 16'hFFFF;
      frame_crc_o <= '0;
      crc_valid_o <= 1'b0;
    end else begin
      crc_valid_o <= 1'b0;
      if (v_edge) begin
        crc_acc <= 16'hFFFF;
        if (state == LOCKED) begin
          frame_crc_o <= crc_cur;
          crc_valid_o <= 1'b1;
        end
      end else begin
        crc_acc <= crc_cur;
      end
    end
  end
`else
  assign frame_crc_o = '0;
  assign crc_valid_o = 1'b0;
`endif

endmodule

// File: tb/tb_vga_rx_decoder.sv
// tb/tb_vga_rx_decoder.sv - scoreboard bench for vga_rx_decoder on a reduced 16x10 timing
`ifndef COLOR_RGB_DEPTH
`define COLOR_RGB_DEPTH 24
`endif
`ifndef H_DISP_LEN
`define H_DISP_LEN 11
`endif
`ifndef V_DISP_LEN
`define V_DISP_LEN 10
`endif

module tb_vga_rx_decoder;
  localparam int H_SYNC = 2, H_BACK = 3, H_DISP = 8, H_TOTAL = 16;
  localparam int V_SYNC = 1, V_BACK = 2, V_DISP = 5, V_TOTAL = 10;
  localparam int HA0 = H_SYNC + H_BACK, VA0 = V_SYNC + V_BACK;
  localparam int RGB_W = `COLOR_RGB_DEPTH;
  localparam int PIX_PER_FRAME = 40;

  logic                   clk_vga = 1'b0;
  logic                   rst;
  logic                   h_sync_i, v_sync_i;
  logic [RGB_W-1:0]       rgb_i;
  logic [`H_DISP_LEN-1:0] x_addr_o;
  logic [`V_DISP_LEN-1:0] y_addr_o;
  logic                   de_o;
  logic [RGB_W-1:0]       rgb_o;
  logic                   locked_o, frame_start_o, line_err_o, frame_err_o;
  logic [15:0]            frame_crc_o;
  logic                   crc_valid_o;

  vga_rx_decoder #(
    .H_SYNC(H_SYNC), .H_BACK(H_BACK), .H_DISP(H_DISP), .H_TOTAL(H_TOTAL),
    .V_SYNC(V_SYNC), .V_BACK(V_BACK), .V_DISP(V_DISP), .V_TOTAL(V_TOTAL),
    .SYNC_POL(1)
  ) dut (
    .clk_vga(clk_vga), .rst(rst), .h_sync_i(h_sync_i), .v_sync_i(v_sync_i),
    .rgb_i(rgb_i), .x_addr_o(x_addr_o), .y_addr_o(y_addr_o), .de_o(de_o),
    .rgb_o(rgb_o), .locked_o(locked_o), .frame_start_o(frame_start_o),
    .line_err_o(line_err_o), .frame_err_o(frame_err_o),
    .frame_crc_o(frame_crc_o), .crc_valid_o(crc_valid_o)
  );

  always #5 clk_vga = ~clk_vga;

  typedef struct {
    int               x;
    int               y;
    logic [RGB_W-1:0] rgb;
    int               cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          rise_q[$], fall_q[$], lerr_q[$], ferr_q[$];
  logic [15:0] crc_hist[$];
  int          t_line[0:15];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          de_count = 0;
  logic        locked_prev = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk_vga);
    cyc++;
  end

  // Monitor: pops one expectation per displayed pixel, logs pulse/lock events by cycle.
  initial forever begin
    exp_t e;
    @(negedge clk_vga);
    if (locked_o && !locked_prev) rise_q.push_back(cyc);
    if (!locked_o && locked_prev) fall_q.push_back(cyc);
    locked_prev = locked_o;
    if (line_err_o) lerr_q.push_back(cyc);
    if (frame_err_o) ferr_q.push_back(cyc);
    if (crc_valid_o) crc_hist.push_back(frame_crc_o);
    if (de_o) begin
      de_count++;
      if (exp_q.size() == 0) begin
        check("unexpected_de", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("x_addr", x_addr_o, e.x);
        check("y_addr", y_addr_o, e.y);
        check("rgb_o", rgb_o, e.rgb);
        check("latency", cyc, e.cyc);
        check("frame_start", frame_start_o, (e.x == 0 && e.y == 0));
      end
    end else begin
      check("idle_outputs_zero", longint'({rgb_o, x_addr_o, y_addr_o, frame_start_o}), 0);
    end
  end

  task automatic drive_lines(input int first, input int last, input int short_line,
                             input int exp_last, input bit zero);
    int   len;
    exp_t ent;
    for (int l = first; l <= last; l++) begin
      len = (l == short_line) ? H_TOTAL - 1 : H_TOTAL;
      for (int c = 0; c < len; c++) begin
        @(negedge clk_vga);
        if (c == 0) t_line[l] = cyc;
        h_sync_i = (c < H_SYNC);
        v_sync_i = (l < V_SYNC);
        if (c >= HA0 && c < HA0 + H_DISP && l >= VA0 && l < VA0 + V_DISP) begin
          rgb_i = zero ? '0 : RGB_W'((c - HA0) ^ (l - VA0));
          if (l <= exp_last) begin
            ent.x   = c - HA0;
            ent.y   = l - VA0;
            ent.rgb = rgb_i;
            ent.cyc = cyc + 2;
            exp_q.push_back(ent);
          end
        end else begin
          rgb_i = RGB_W'($urandom);
        end
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_locked"}, locked_o, 0);
    check({tag, "_de"}, de_o, 0);
    check({tag, "_x"}, x_addr_o, 0);
    check({tag, "_y"}, y_addr_o, 0);
    check({tag, "_rgb"}, rgb_o, 0);
    check({tag, "_frame_start"}, frame_start_o, 0);
    check({tag, "_line_err"}, line_err_o, 0);
    check({tag, "_frame_err"}, frame_err_o, 0);
    check({tag, "_crc"}, frame_crc_o, 0);
    check({tag, "_crc_valid"}, crc_valid_o, 0);
  endtask

`ifdef VGA_RX_CRC_EN
  function automatic logic [15:0] crc_zero_frame();
    logic [15:0] c;
    c = 16'hFFFF;
    for (int p = 0; p < PIX_PER_FRAME * RGB_W; p++)
      c = {c[14:0], 1'b0} ^ (c[15] ? 16'h1021 : 16'h0000);
    return c;
  endfunction
`endif

  initial begin
    int d0, c0, t_rst;
    rst = 1'b1; h_sync_i = 1'b0; v_sync_i = 1'b0; rgb_i = '0;
    repeat (3) @(negedge clk_vga);
    check_all_zero("reset");
    rst = 1'b0;

    // Nominal acquisition: lock one cycle after the second v edge's output slot.
    drive_lines(0, 9, -1, -1, 1'b0);
    check("unlocked_after_first_frame", locked_o, 0);
    drive_lines(0, 9, -1, 9, 1'b0);
    check("lock_rise_count", rise_q.size(), 1);
    if (rise_q.size() >= 1) check("lock_rise_time", rise_q[0], t_line[0] + 2);
    d0 = de_count;
    drive_lines(0, 9, -1, 9, 1'b0);
    check("de_per_frame", de_count - d0, PIX_PER_FRAME);
    drive_lines(0, 9, -1, 9, 1'b0);
    check("nominal_line_errs", lerr_q.size(), 0);
    check("nominal_frame_errs", ferr_q.size(), 0);
    check("nominal_locked", locked_o, 1);

    // One line of H_TOTAL-1 clocks.
    drive_lines(0, 9, 5, 5, 1'b0);
    check("short_line_err_count", lerr_q.size(), 1);
    if (lerr_q.size() >= 1) check("short_line_err_time", lerr_q[0], t_line[6] + 2);
    check("short_line_fall_count", fall_q.size(), 1);
    if (fall_q.size() >= 1) check("short_line_fall_time", fall_q[0], t_line[6] + 2);
    drive_lines(0, 9, -1, -1, 1'b0);
    check("acq_not_locked", locked_o, 0);
    drive_lines(0, 9, -1, 9, 1'b0);
    check("relock_count", rise_q.size(), 2);
    if (rise_q.size() >= 2) check("relock_time", rise_q[1], t_line[0] + 2);
    check("short_line_no_frame_err", ferr_q.size(), 0);

    // Frame of V_TOTAL-1 lines.
    drive_lines(0, 8, -1, 9, 1'b0);
    drive_lines(0, 9, -1, -1, 1'b0);
    check("short_frame_err_count", ferr_q.size(), 1);
    if (ferr_q.size() >= 1) check("short_frame_err_time", ferr_q[0], t_line[0] + 2);
    check("short_frame_fall_count", fall_q.size(), 2);
    if (fall_q.size() >= 2) check("short_frame_fall_time", fall_q[1], t_line[0] + 2);
    drive_lines(0, 9, -1, -1, 1'b0);
    drive_lines(0, 9, -1, 9, 1'b0);
    check("relock2_count", rise_q.size(), 3);
    if (rise_q.size() >= 3) check("relock2_time", rise_q[2], t_line[0] + 2);
    check("short_frame_line_errs", lerr_q.size(), 1);

    // Reset mid-frame, then reacquire with no errors on the first edges.
    drive_lines(0, 3, -1, 3, 1'b0);
    check("pre_reset_queue_empty", exp_q.size(), 0);
    check("pre_reset_locked", locked_o, 1);
    @(negedge clk_vga);
    t_rst = cyc;
    rst = 1'b1; h_sync_i = 1'b0; v_sync_i = 1'b0;
    @(negedge clk_vga);
    check_all_zero("mid_reset");
    check("mid_reset_fall_count", fall_q.size(), 3);
    rst = 1'b0;
    drive_lines(4, 9, -1, -1, 1'b0);
    drive_lines(0, 9, -1, -1, 1'b0);
    drive_lines(0, 9, -1, 9, 1'b0);
    if (fall_q.size() >= 3) check("mid_reset_fall_time", fall_q[2], t_rst + 1);
    check("post_reset_line_errs", lerr_q.size(), 1);
    check("post_reset_frame_errs", ferr_q.size(), 1);
    check("post_reset_relock_count", rise_q.size(), 4);
    if (rise_q.size() >= 4) check("post_reset_relock_time", rise_q[3], t_line[0] + 2);

    // Two constant-zero frames, then a nominal frame whose v edge reports the second one.
    c0 = crc_hist.size();
    drive_lines(0, 9, -1, 9, 1'b1);
    drive_lines(0, 9, -1, 9, 1'b1);
    drive_lines(0, 9, -1, 9, 1'b0);
`ifdef VGA_RX_CRC_EN
    check("crc_valid_per_frame", crc_hist.size() - c0, 3);
    if (crc_hist.size() >= 2) begin
      check("crc_zero_frame_a", crc_hist[crc_hist.size() - 2], crc_zero_frame());
      check("crc_zero_frame_b", crc_hist[crc_hist.size() - 1], crc_zero_frame());
    end
`else
    check("crc_valid_never", crc_hist.size() + c0, 0);
    check("crc_value_zero", frame_crc_o, 0);
`endif

    h_sync_i = 1'b0; v_sync_i = 1'b0;
    repeat (4) @(negedge clk_vga);
    check("final_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/vga_rx_decoder.md
VGA_RX_DECODER -- requirements
Module: vga_rx_decoder

Interface
REQ-001 SHALL have parameter H_SYNC, default 128, hsync pulse width in pixel clocks.
REQ-002 SHALL have parameter H_BACK, default 88, clocks from hsync start-edge end-of-pulse to first active pixel.
REQ-003 SHALL have parameters H_DISP (800) and H_TOTAL (1056), active pixels and clocks per line.
REQ-004 SHALL have parameters V_SYNC (4), V_BACK (23), V_DISP (600) and V_TOTAL (628), in lines.
REQ-005 SHALL have parameter SYNC_POL, default 1, asserted level of both syncs.
REQ-006 clk_vga  in  1  pixel clock; the only clock.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 h_sync_i, v_sync_i  in  1 each  incoming sync stream.
REQ-009 rgb_i  in  `COLOR_RGB_DEPTH  incoming pixel colour.
REQ-010 x_addr_o  out  `H_DISP_LEN  recovered column; y_addr_o  out  `V_DISP_LEN  recovered row.
REQ-011 de_o  out  1  active-pixel flag; rgb_o  out  `COLOR_RGB_DEPTH  pixel aligned to de_o.
REQ-012 locked_o  out  1; frame_start_o  out  1 (pulse); line_err_o  out  1 (pulse); frame_err_o  out  1 (pulse).
REQ-013 frame_crc_o  out  16; crc_valid_o  out  1 (pulse).

Function
REQ-014 Stage 1 SHALL register h_sync_i, v_sync_i, rgb_i together; edges detected against the previous stage-1 value.
REQ-015 A start edge is the stage-1 transition into SYNC_POL level.
REQ-016 hcnt (11 bit) SHALL load 0 on an h start edge, else increment, saturating at 2047.
REQ-017 vcnt (10 bit) SHALL load 0 on a v start edge, else increment on each h start edge, saturating at 1023.
REQ-018 Simultaneous h and v start edges: vcnt SHALL load 0 (no increment), hcnt SHALL load 0.
REQ-019 On each h start edge, line_err_o SHALL pulse one cycle if the previous hcnt+1 != H_TOTAL; not on the first h edge after reset.
REQ-020 On each v start edge, frame_err_o SHALL pulse if previous vcnt+1 != V_TOTAL; not on the first v edge after reset.
REQ-021 Lock FSM states UNLOCK, ACQ, LOCKED: UNLOCK->ACQ on v edge; ACQ->LOCKED on v edge with no frame_err and no line_err since previous v edge, else stays ACQ; LOCKED->UNLOCK on any line_err or frame_err.
REQ-022 locked_o SHALL be 1 exactly in LOCKED, registered, one cycle after the deciding edge.
REQ-023 de_o SHALL be 1 when locked and H_SYNC+H_BACK <= hcnt < H_SYNC+H_BACK+H_DISP and V_SYNC+V_BACK <= vcnt < V_SYNC+V_BACK+V_DISP.
REQ-024 x_addr_o/y_addr_o SHALL equal hcnt-(H_SYNC+H_BACK) / vcnt-(V_SYNC+V_BACK) when de_o=1, else 0.
REQ-025 de_o, x/y, rgb_o SHALL appear 2 clk_vga after the input sample (stage 1 + output register); rgb_o=0 when de_o=0.
REQ-026 frame_start_o SHALL pulse one cycle with x=0,y=0 on the first de_o of each frame.

Reset
REQ-027 rst SHALL clear all counters, stage registers and CRC, set FSM to UNLOCK, and drive every output to 0 on the next edge; rst mid-frame discards the frame and forces reacquisition.
REQ-028 After rst the first h and v edges SHALL be treated as "first edge" (no error checks).

Configuration
REQ-029 With VGA_RX_CRC_EN defined: CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB-first, rgb_o bits MSB first) SHALL accumulate over every de_o pixel; on each v edge while locked, frame_crc_o SHALL load the result, crc_valid_o pulse once, CRC re-initialise.
REQ-030 Without VGA_RX_CRC_EN: no CRC logic; frame_crc_o and crc_valid_o SHALL be constant 0.

Verification
REQ-031 Nominal 800x600 stream from rst -> locked_o=1 one cycle after 2nd v edge; zero line_err/frame_err; de_o count 480000 per locked frame.
REQ-032 Locked, one line of 1055 clocks -> line_err_o one pulse at next h edge, locked_o=0 next cycle, relock after two further v edges.
REQ-033 Locked, frame of 627 lines -> frame_err_o pulse at v edge, locked_o drops.
REQ-034 Pixel rgb_i = x xor y at input -> rgb_o matches x_addr_o xor y_addr_o with 2-cycle latency; frame_start_o at x=0,y=0 only.
REQ-035 rst asserted at line 300 -> all outputs 0 next cycle; no err pulse on first edges afterward.
REQ-036 VGA_RX_CRC_EN, constant rgb_i=0 frame -> crc_valid_o one pulse per locked frame, frame_crc_o identical across frames; without macro both stay 0.
